// File: rtl/ex_wb_elastic_stage_pkg.sv
// Shared definitions for the EX->WB elastic stage: occupancy states,
// default widths and the packed pipeline entry layout.
package ex_wb_elastic_stage_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int RD_W_DEF    = 3;
    localparam int NUM_SRC_DEF = 2;

    // Occupancy of the two-entry stage: nothing, main only, main plus skid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    // One EX result travelling to WB, at the default widths.
    typedef struct packed {
        logic                  regwrite;
        logic [RD_W_DEF-1:0]   rd;
        logic [DATA_W_DEF-1:0] result;
    } entry_t;

endpackage

// File: rtl/ex_wb_elastic_stage_if.sv
// Handshake, writeback and forwarding-lookup signals of the EX->WB stage.
// master = EX/WB/decode side driving the stage, slave = the stage itself.
interface ex_wb_elastic_stage_if
    import ex_wb_elastic_stage_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int RD_W    = RD_W_DEF,
    parameter int NUM_SRC = NUM_SRC_DEF
) ();

    logic                      flush;
    logic                      in_valid;
    logic                      in_ready;
    logic                      in_regwrite;
    logic [DATA_W-1:0]         in_result;
    logic [RD_W-1:0]           in_rd;
    logic                      out_valid;
    logic                      out_ready;
    logic                      out_regwrite;
    logic [DATA_W-1:0]         out_result;
    logic [RD_W-1:0]           out_rd;
    logic [NUM_SRC*RD_W-1:0]   fwd_src_rd;
    logic [NUM_SRC-1:0]        fwd_hit;
    logic [NUM_SRC*DATA_W-1:0] fwd_data;

    modport master (
        output flush, in_valid, in_regwrite, in_result, in_rd, out_ready, fwd_src_rd,
        input  in_ready, out_valid, out_regwrite, out_result, out_rd, fwd_hit, fwd_data
    );

    modport slave (
        input  flush, in_valid, in_regwrite, in_result, in_rd, out_ready, fwd_src_rd,
        output in_ready, out_valid, out_regwrite, out_result, out_rd, fwd_hit, fwd_data
    );

endinterface

// File: rtl/ex_wb_elastic_stage_fwd_match.sv
// Single forwarding lookup port: compares one source index against the
// main and skid entries, the younger skid entry taking precedence.
module fwd_match
    import ex_wb_elastic_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_W   = RD_W_DEF
) (
    input  logic [RD_W-1:0]   src_rd,
    input  logic              main_vld,
    input  logic              main_wen,
    input  logic [RD_W-1:0]   main_rd,
    input  logic [DATA_W-1:0] main_result,
    input  logic              skid_vld,
    input  logic              skid_wen,
    input  logic [RD_W-1:0]   skid_rd,
    input  logic [DATA_W-1:0] skid_result,
    output logic              hit,
    output logic [DATA_W-1:0] data
);

    logic src_nz;
    logic main_hit;
    logic skid_hit;

    // Per-entry match, then priority select with zero on miss.
    always_comb begin
        src_nz   = (src_rd != '0);
        main_hit = main_vld & main_wen & src_nz & (main_rd == src_rd);
        skid_hit = skid_vld & skid_wen & src_nz & (skid_rd == src_rd);
        hit      = main_hit | skid_hit;
        data     = '0;
        if (skid_hit) begin
            data = skid_result;
        end else if (main_hit) begin
            data = main_result;
        end
    end

endmodule

// File: rtl/ex_wb_elastic_stage.sv
// EX->WB elastic (skid) stage: a main register feeding WB directly and a
// skid register behind it so in_ready can be registered without losing
// throughput. Also answers forwarding lookups from the held entries.
module ex_wb_elastic_stage
    import ex_wb_elastic_stage_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int RD_W    = RD_W_DEF,
    parameter int NUM_SRC = NUM_SRC_DEF
) (
    input  logic clk,
    input  logic rst,
    ex_wb_elastic_stage_if.slave bus
);

    // Width-parameterised view of entry_t.
    typedef struct packed {
        logic              regwrite;
        logic [RD_W-1:0]   rd;
        logic [DATA_W-1:0] result;
    } ent_t;

    state_t state_p0;
    logic   in_ready_p0;
    ent_t   main_p0;
    ent_t   skid_p0;

    ent_t   in_ent;
    logic   out_vld;
    logic   skid_vld;
    logic   acc;
    logic   pop;

    logic [NUM_SRC-1:0]        hit_w;
    logic [NUM_SRC*DATA_W-1:0] data_w;

    // Incoming entry with the write enable qualified: x0 is never written.
    always_comb begin
        in_ent.regwrite = bus.in_regwrite & (bus.in_rd != '0);
        in_ent.rd       = bus.in_rd;
        in_ent.result   = bus.in_result;
        out_vld         = (state_p0 != EMPTY);
        skid_vld        = (state_p0 == FULL);
        acc             = bus.in_valid & in_ready_p0;
        pop             = out_vld & bus.out_ready;
    end

    // Occupancy FSM with registered in_ready; data registers load only on a move.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_p0    <= EMPTY;
            in_ready_p0 <= 1'b1;
            main_p0     <= '0;
            skid_p0     <= '0;
        end else if (bus.flush) begin
            state_p0    <= EMPTY;
            in_ready_p0 <= 1'b1;
        end else begin
            case (state_p0)
                EMPTY: begin
                    in_ready_p0 <= 1'b1;
                    if (acc) begin
                        main_p0  <= in_ent;
                        state_p0 <= ONE;
                    end
                end
                ONE: begin
                    if (acc && pop) begin
                        main_p0     <= in_ent;
                        in_ready_p0 <= 1'b1;
                    end else if (acc) begin
                        skid_p0     <= in_ent;
                        state_p0    <= FULL;
                        in_ready_p0 <= 1'b0;
                    end else if (pop) begin
                        state_p0    <= EMPTY;
                        in_ready_p0 <= 1'b1;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a pop can move anything.
                    if (pop) begin
                        main_p0     <= skid_p0;
                        state_p0    <= ONE;
                        in_ready_p0 <= 1'b1;
                    end
                end
                default: begin
                    state_p0    <= EMPTY;
                    in_ready_p0 <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready     = in_ready_p0;
    assign bus.out_valid    = out_vld;
    assign bus.out_regwrite = main_p0.regwrite;
    assign bus.out_result   = main_p0.result;
    assign bus.out_rd       = main_p0.rd;

    // Forwarding lookups see register contents only, independent of flush.
    for (genvar k = 0; k < NUM_SRC; k++) begin : g_fwd
        fwd_match #(
            .DATA_W (DATA_W),
            .RD_W   (RD_W)
        ) u_match (
            .src_rd      (bus.fwd_src_rd[k*RD_W +: RD_W]),
            .main_vld    (out_vld),
            .main_wen    (main_p0.regwrite),
            .main_rd     (main_p0.rd),
            .main_result (main_p0.result),
            .skid_vld    (skid_vld),
            .skid_wen    (skid_p0.regwrite),
            .skid_rd     (skid_p0.rd),
            .skid_result (skid_p0.result),
            .hit         (hit_w[k]),
            .data        (data_w[k*DATA_W +: DATA_W])
        );
    end

    assign bus.fwd_hit  = hit_w;
    assign bus.fwd_data = data_w;

endmodule

// File: tb/tb_ex_wb_elastic_stage.sv
// Bench for ex_wb_elastic_stage: directed scenarios with literal
// expectations plus randomized traffic against a queue-based model.
module tb_ex_wb_elastic_stage;
    import ex_wb_elastic_stage_pkg::*;

    logic clk;
    logic rst;

    ex_wb_elastic_stage_if #(.DATA_W(8), .RD_W(3), .NUM_SRC(2)) bus ();

    ex_wb_elastic_stage #(.DATA_W(8), .RD_W(3), .NUM_SRC(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    entry_t q[$];
    entry_t hold;
    entry_t e_new;
    entry_t exp_out;
    logic   m_rdy;
    bit     known = 0;
    bit     m_pop, m_acc;
    logic [2:0] s_rd;
    logic       e_hit;
    logic [7:0] e_dat;

    always @(posedge clk) begin
        if (!rst) begin
            q.delete();
            m_rdy = 1'b1;
            hold  = '0;
            known = 1;
        end else if (known) begin
            m_pop = (q.size() > 0) && (bus.out_ready === 1'b1);
            m_acc = (bus.in_valid === 1'b1) && m_rdy;
            if (bus.flush === 1'b1) begin
                q.delete();
            end else begin
                if (m_pop) void'(q.pop_front());
                if (m_acc) begin
                    e_new.regwrite = bus.in_regwrite && (bus.in_rd != 3'd0);
                    e_new.rd       = bus.in_rd;
                    e_new.result   = bus.in_result;
                    q.push_back(e_new);
                end
            end
            m_rdy = (q.size() < 2);
            if (q.size() > 0) hold = q[0];
        end
    end

    always @(negedge clk) begin
        if (known) begin
            check("out_valid", {31'd0, bus.out_valid}, {31'd0, q.size() > 0});
            check("in_ready", {31'd0, bus.in_ready}, {31'd0, m_rdy});
            exp_out = (q.size() > 0) ? q[0] : hold;
            check("out_rd", {29'd0, bus.out_rd}, {29'd0, exp_out.rd});
            check("out_result", {24'd0, bus.out_result}, {24'd0, exp_out.result});
            check("out_regwrite", {31'd0, bus.out_regwrite}, {31'd0, exp_out.regwrite});
            for (int k = 0; k < 2; k++) begin
                s_rd  = bus.fwd_src_rd[k*3 +: 3];
                e_hit = 1'b0;
                e_dat = 8'd0;
                for (int i = q.size() - 1; i >= 0; i--) begin
                    if (!e_hit && q[i].regwrite && q[i].rd == s_rd && s_rd != 3'd0) begin
                        e_hit = 1'b1;
                        e_dat = q[i].result;
                    end
                end
                check("fwd_hit", {31'd0, bus.fwd_hit[k]}, {31'd0, e_hit});
                check("fwd_data", {24'd0, bus.fwd_data[k*8 +: 8]}, {24'd0, e_dat});
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic rw, input logic [2:0] rd, input logic [7:0] res);
        bus.in_valid    = v;
        bus.in_regwrite = rw;
        bus.in_rd       = rd;
        bus.in_result   = res;
    endtask

    initial begin
        rst            = 1'b0;
        bus.flush      = 1'b0;
        bus.out_ready  = 1'b0;
        bus.fwd_src_rd = 6'd0;
        offer(1'b0, 1'b0, 3'd0, 8'd0);

        // reset state
        tick();
        tick();
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_fwd_hit", {30'd0, bus.fwd_hit}, 32'd0);
        rst = 1'b1;
        tick();

        // streaming with out_ready held high
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            offer(1'b1, 1'b1, 3'(i), 8'(i * 8'h11));
            tick();
            check("stream_valid", {31'd0, bus.out_valid}, 32'd1);
            check("stream_rd", {29'd0, bus.out_rd}, i);
            check("stream_result", {24'd0, bus.out_result}, i * 32'h11);
            check("stream_in_ready", {31'd0, bus.in_ready}, 32'd1);
        end
        offer(1'b0, 1'b0, 3'd0, 8'd0);
        tick();
        check("stream_drained", {31'd0, bus.out_valid}, 32'd0);

        // backpressure
        bus.out_ready = 1'b0;
        offer(1'b1, 1'b1, 3'd1, 8'hA1);
        tick();
        offer(1'b1, 1'b1, 3'd2, 8'hA2);
        tick();
        check("bp_full_ready", {31'd0, bus.in_ready}, 32'd0);
        offer(1'b1, 1'b1, 3'd3, 8'hA3);
        tick();
        check("bp_blocked_ready", {31'd0, bus.in_ready}, 32'd0);
        check("bp_head_rd", {29'd0, bus.out_rd}, 32'd1);
        bus.out_ready = 1'b1;
        tick();
        check("bp_second_rd", {29'd0, bus.out_rd}, 32'd2);
        check("bp_ready_back", {31'd0, bus.in_ready}, 32'd1);
        tick();
        check("bp_third_rd", {29'd0, bus.out_rd}, 32'd3);
        check("bp_third_res", {24'd0, bus.out_result}, 32'hA3);
        offer(1'b0, 1'b0, 3'd0, 8'd0);
        tick();

        // x0 suppression
        bus.out_ready  = 1'b0;
        bus.fwd_src_rd = 6'd0;
        offer(1'b1, 1'b1, 3'd0, 8'hFF);
        tick();
        offer(1'b0, 1'b0, 3'd0, 8'd0);
        check("x0_valid", {31'd0, bus.out_valid}, 32'd1);
        check("x0_regwrite", {31'd0, bus.out_regwrite}, 32'd0);
        check("x0_fwd_hit", {30'd0, bus.fwd_hit}, 32'd0);
        bus.out_ready = 1'b1;
        tick();

        // forwarding priority: skid beats main
        bus.out_ready  = 1'b0;
        bus.fwd_src_rd = {3'd3, 3'd5};
        offer(1'b1, 1'b1, 3'd5, 8'h0A);
        tick();
        offer(1'b1, 1'b1, 3'd5, 8'h0B);
        tick();
        offer(1'b0, 1'b0, 3'd0, 8'd0);
        check("fwd_pri_hit", {30'd0, bus.fwd_hit}, 32'd1);
        check("fwd_pri_data", {24'd0, bus.fwd_data[7:0]}, 32'h0B);
        check("fwd_pri_main", {24'd0, bus.out_result}, 32'h0A);
        bus.out_ready = 1'b1;
        tick();
        check("fwd_pop_data", {24'd0, bus.fwd_data[7:0]}, 32'h0B);
        check("fwd_pop_hit", {30'd0, bus.fwd_hit}, 32'd1);
        tick();
        check("fwd_drained", {31'd0, bus.out_valid}, 32'd0);

        // flush while full with a simultaneous offer
        bus.out_ready  = 1'b0;
        bus.fwd_src_rd = {3'd2, 3'd1};
        offer(1'b1, 1'b1, 3'd1, 8'h31);
        tick();
        offer(1'b1, 1'b1, 3'd2, 8'h32);
        tick();
        bus.flush = 1'b1;
        offer(1'b1, 1'b1, 3'd6, 8'h66);
        tick();
        bus.flush = 1'b0;
        offer(1'b0, 1'b0, 3'd0, 8'd0);
        check("flush_valid", {31'd0, bus.out_valid}, 32'd0);
        check("flush_ready", {31'd0, bus.in_ready}, 32'd1);
        check("flush_fwd_hit", {30'd0, bus.fwd_hit}, 32'd0);
        bus.out_ready = 1'b1;
        tick();
        check("flush_no_ghost", {31'd0, bus.out_valid}, 32'd0);

        // reset while full
        bus.out_ready  = 1'b0;
        bus.fwd_src_rd = {3'd4, 3'd3};
        offer(1'b1, 1'b1, 3'd3, 8'h43);
        tick();
        offer(1'b1, 1'b1, 3'd4, 8'h44);
        tick();
        rst = 1'b0;
        offer(1'b1, 1'b1, 3'd6, 8'h66);
        tick();
        rst = 1'b1;
        offer(1'b0, 1'b0, 3'd0, 8'd0);
        check("rst2_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst2_regwrite", {31'd0, bus.out_regwrite}, 32'd0);
        check("rst2_result", {24'd0, bus.out_result}, 32'd0);
        check("rst2_rd", {29'd0, bus.out_rd}, 32'd0);
        check("rst2_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst2_fwd_hit", {30'd0, bus.fwd_hit}, 32'd0);
        bus.out_ready = 1'b1;
        offer(1'b1, 1'b1, 3'd7, 8'h5A);
        tick();
        offer(1'b0, 1'b0, 3'd0, 8'd0);
        check("rst2_first_valid", {31'd0, bus.out_valid}, 32'd1);
        check("rst2_first_rd", {29'd0, bus.out_rd}, 32'd7);
        check("rst2_first_res", {24'd0, bus.out_result}, 32'h5A);
        tick();

        // randomized traffic checked every cycle by the model
        for (int n = 0; n < 3000; n++) begin
            offer($urandom_range(3) != 0, 1'($urandom), 3'($urandom), 8'($urandom));
            bus.out_ready  = ($urandom_range(2) != 0);
            bus.flush      = ($urandom_range(31) == 0);
            rst            = ($urandom_range(127) != 0);
            bus.fwd_src_rd = 6'($urandom);
            tick();
        end

        rst       = 1'b1;
        bus.flush = 1'b0;
        offer(1'b0, 1'b0, 3'd0, 8'd0);
        tick();
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_wb_elastic_stage.md
EX_WB_ELASTIC_STAGE -- requirements
Module: ex_wb_elastic_stage

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset: `clk` is the only clock, and `rst` is sampled on the rising edge of `clk`, with 0 meaning reset.
REQ-002 Parameters (name, default, meaning):
- DATA_W, 8, width of the ALU result.
- RD_W, 3, width of the destination register index.
- NUM_SRC, 2, number of forwarding lookup ports.
REQ-003 Ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst, in, 1, synchronous active-low reset.
- flush, in, 1, discard all held entries.
- in_valid, in, 1, EX presents an entry.
- in_ready, out, 1, stage can accept an entry.
- in_regwrite, in, 1, entry writes the register file.
- in_result, in, DATA_W, ALU result.
- in_rd, in, RD_W, destination index.
- out_valid, out, 1, WB entry valid.
- out_ready, in, 1, WB consumes the entry.
- out_regwrite, out, 1, qualified write enable.
- out_result, out, DATA_W, result to WB.
- out_rd, out, RD_W, destination to WB.
- fwd_src_rd, in, NUM_SRC*RD_W, packed source indices to look up.
- fwd_hit, out, NUM_SRC, per-port match flag.
- fwd_data, out, NUM_SRC*DATA_W, per-port forwarded value.

Function
REQ-004 The stage SHALL hold up to two entries: a main register driving the out_* ports, and a skid register behind it.
REQ-005 Occupancy state SHALL be one of three states:
- EMPTY: no entry held.
- ONE: main register only.
- FULL: main and skid registers.
REQ-006 A transfer SHALL occur on the input side when in_valid&in_ready, and on the output side when out_valid&out_ready, both evaluated at the rising edge.
REQ-007 in_ready SHALL be a registered signal equal to (state != FULL).
REQ-008 out_valid SHALL equal (state != EMPTY).
REQ-009 EMPTY transitions:
- Input accept loads main and moves to ONE.
- Otherwise the state stays EMPTY.
REQ-010 ONE transitions:
- Accept and pop together reload main and stay in ONE.
- Accept only loads skid and moves to FULL.
- Pop only moves to EMPTY.
REQ-011 FULL transitions:
- Pop moves skid into main and goes to ONE.
- No accept is possible in FULL.
REQ-012 Latency from input accept to out_valid SHALL be one cycle when the stage is EMPTY, or when it is ONE with a simultaneous pop. Throughput SHALL be one entry per cycle while out_ready stays high.
REQ-013 Entry order SHALL be preserved, with no loss and no duplication.
REQ-014 A stored write enable SHALL be in_regwrite & (in_rd != 0), since register x0 is never written.
REQ-015 out_result, out_rd and out_regwrite SHALL be driven directly from the main register, with no combinational path from in_* to out_*.
REQ-016 When flush=1, the next state SHALL be EMPTY regardless of other inputs. Any in_valid presented in that cycle SHALL be dropped, and in_ready SHALL be 1 on the following cycle.
REQ-017 Flush SHALL take priority over accept and over pop. A pop in the flush cycle still counts as consumed by WB.
REQ-018 Forwarding lookup SHALL be combinational:
- For port k, a hit is a valid entry with its write enable set whose rd equals fwd_src_rd[k] and is nonzero.
- The skid entry (younger) SHALL win over the main entry.
- fwd_data[k] SHALL be 0 when there is no hit.
REQ-019 Lookups SHALL ignore flush within the same cycle, reflecting only register contents.
REQ-020 Data registers SHALL NOT update when they are not loaded, which holds values stable under backpressure.

Reset
REQ-021 While rst=0 at a clock edge, the state SHALL become EMPTY and in_ready SHALL become 1.
REQ-022 Reset SHALL clear out_valid, out_regwrite, out_result and out_rd to 0, and clear the skid register to 0.
REQ-023 Reset asserted mid-stream SHALL discard all entries. Reset SHALL take priority over flush and over all handshakes.
REQ-024 fwd_hit SHALL be all-zero in the cycle after reset.

Structure
REQ-025 A shared package SHALL hold:
- The state enum (EMPTY, ONE, FULL).
- The default DATA_W and RD_W constants.
- A packed entry typedef {regwrite, rd, result}.
REQ-026 The forwarding compare for a single port SHALL be one sub-module, `fwd_match`, instantiated NUM_SRC times by a generate loop.
REQ-027 Target implementation size is 120-400 lines of RTL.

Verification
REQ-028 Streaming: 4 entries (rd=1..4, result=0x11..0x44, regwrite=1) with out_ready=1 held high -> each appears exactly one cycle after its accept, in order, and in_ready stays 1 throughout.
REQ-029 Backpressure: out_ready=0 while 3 entries are offered -> 2 are accepted and in_ready falls to 0. Raising out_ready then drains rd=1 followed by rd=2, and the third entry is accepted after one pop.
REQ-030 x0 suppression: regwrite=1, rd=0, result=0xFF -> out_regwrite=0 and fwd_hit=0 for fwd_src_rd=0.
REQ-031 Forward priority: main holds rd=5/0x0A and skid holds rd=5/0x0B, lookup on rd=5 -> fwd_hit=1 and fwd_data=0x0B. After one pop, fwd_data=0x0B.
REQ-032 Flush: with the stage FULL, flush=1 together with in_valid=1 -> the next cycle shows out_valid=0, in_ready=1 and fwd_hit=0, and the offered entry never appears at the output.
REQ-033 Reset: rst=0 for one edge while FULL -> all outputs are 0 and in_ready=1. The first entry after reset (rd=7, 0x5A) appears one cycle later.
